vga_timing_controller: RTL and testbench

// - Display-side end of the pixel interface. Generates raw beam coordinates (x, y) for the frame

---
 rtl/vga_pkg.sv | 52 +++++
 rtl/vga_timing_controller_if.sv | 41 ++++
 rtl/sync_delay_line.sv | 45 ++++
 rtl/vga_timing_controller.sv | 159 +++++++++++++++
 tb/tb_vga_timing_controller.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Package: vga_pkg
// Shared timing constants and types for the VGA timing controller.
//   - Default 640x480@60 timing numbers and the derived totals and active windows.
//   - coord_t: raw beam coordinate type.
//   - rgb_t: 24-bit colour as separate 8-bit channels.
//   - timing_t: the raw {hs, vs, act} flags carried down the alignment pipeline.
//   - bar_color(): colour of one of the eight test-pattern bars.
package vga_pkg;

  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;  // 800
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;  // 525
  localparam int H_ACT_START = H_SYNC + H_BP;                    // 144
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;           // 784 (exclusive)
  localparam int V_ACT_START = V_SYNC + V_BP;                    // 35
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;           // 515 (exclusive)

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // hs/vs are "inside the sync pulse", act is "visible pixel"; polarity is
  // applied only at the output register.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } timing_t;

  // Bars 0..7: white, yellow, cyan, green, magenta, red, blue, black.
  // Each channel is a single bit of the inverted bar index.
  function automatic rgb_t bar_color(input logic [2:0] bar);
    rgb_t c;
    c.r = {8{~bar[1]}};
    c.g = {8{~bar[2]}};
    c.b = {8{~bar[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_controller_if.sv
// Interface: vga_timing_controller_if
// Pixel-side bundle between the renderer/board and the VGA timing controller.
//   master (renderer side): drives pix_en, rgb_color[, test_mode]; receives the rest.
//   slave  (controller)   : receives pix_en, rgb_color[, test_mode]; drives
//                           x, y, frame_start, hsync, vsync, blank_n, vga_r/g/b.
// Optional: TEST_PATTERN_EN adds the test_mode signal.
interface vga_timing_controller_if;
  import vga_pkg::*;

  logic        pix_en;
  logic [23:0] rgb_color;
`ifdef TEST_PATTERN_EN
  logic        test_mode;
`endif
  coord_t      x;
  coord_t      y;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (
    output pix_en, rgb_color,
`ifdef TEST_PATTERN_EN
    output test_mode,
`endif
    input  x, y, frame_start, hsync, vsync, blank_n, vga_r, vga_g, vga_b
  );

  modport slave (
    input  pix_en, rgb_color,
`ifdef TEST_PATTERN_EN
    input  test_mode,
`endif
    output x, y, frame_start, hsync, vsync, blank_n, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/sync_delay_line.sv
// Module: sync_delay_line
// Enable-gated shift register of DEPTH stages, WIDTH bits each, with an
// asynchronous active-low clear to all zeros.
//   clk   in  clock
//   rst_n in  async active-low clear
//   en    in  shift enable (holds all stages when low)
//   din   in  WIDTH  data into stage 0
//   dout  out WIDTH  data from the last stage (DEPTH enabled cycles late)
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // NOTE: these stages are ordinary flops, not a RAM, so they are cleared; zero means blanked/inactive.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_controller.sv
// Module: vga_timing_controller
// Display-side end of the pixel interface: raw beam counters (x, y) go out to
// the renderer, its colour comes back PIX_LAT enabled cycles later, and the
// sync/blank flags are delayed by the same amount so the pins line up.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   vif    slave modport: pix_en, rgb_color[, test_mode] in;
//          x, y, frame_start, hsync, vsync, blank_n, vga_r/g/b out
// Optional: TEST_PATTERN_EN replaces rgb_color with 8 vertical colour bars
// when test_mode=1.
module vga_timing_controller #(
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int PIX_LAT  = 2,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  vga_timing_controller_if.slave  vif
);
  import vga_pkg::*;

  localparam int H_LAST   = H_SYNC + H_BP + H_ACTIVE + H_FP - 1;
  localparam int V_LAST   = V_SYNC + V_BP + V_ACTIVE + V_FP - 1;
  localparam int HA_START = H_SYNC + H_BP;
  localparam int HA_END   = HA_START + H_ACTIVE;
  localparam int VA_START = V_SYNC + V_BP;
  localparam int VA_END   = VA_START + V_ACTIVE;

  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_pix_lat
    $error("vga_timing_controller: PIX_LAT must be in 1..4");
  end

  coord_t  x_q, x_d, y_q, y_d;
  logic    frame_start_q, frame_start_d;
  timing_t raw, dly;
  logic    hsync_q, hsync_d, vsync_q, vsync_d, blank_n_q, blank_n_d;
  rgb_t    rgb_q, rgb_d, pix_rgb;

  // Beam counters. frame_start is registered from the coordinate currently
  // presented, so the pulse appears on the first enabled cycle after (0,0).
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = frame_start_q;
    if (vif.pix_en) begin
      frame_start_d = (x_q == '0) && (y_q == '0);
      if (x_q == coord_t'(H_LAST)) begin
        x_d = '0;
        y_d = (y_q == coord_t'(V_LAST)) ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Stage 0 timing flags, straight from the counters.
  assign raw.hs  = (x_q < coord_t'(H_SYNC));
  assign raw.vs  = (y_q < coord_t'(V_SYNC));
  assign raw.act = (x_q >= coord_t'(HA_START)) && (x_q < coord_t'(HA_END)) &&
                   (y_q >= coord_t'(VA_START)) && (y_q < coord_t'(VA_END));

  sync_delay_line #(
    .WIDTH ($bits(timing_t)),
    .DEPTH (PIX_LAT)
  ) u_timing_dly (
    .clk   (clk),
    .rst_n (reset),
    .en    (vif.pix_en),
    .din   (raw),
    .dout  (dly)
  );

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  coord_t     x_dly, col;
  logic [2:0] bar;

  // The bar index comes from x delayed like the sync flags, so bar edges
  // sit at fixed offsets from hsync.
  sync_delay_line #(
    .WIDTH ($bits(coord_t)),
    .DEPTH (PIX_LAT)
  ) u_x_dly (
    .clk   (clk),
    .rst_n (reset),
    .en    (vif.pix_en),
    .din   (x_q),
    .dout  (x_dly)
  );

  // Outside the active window col/bar are meaningless; act masks them.
  always_comb begin
    col     = x_dly - coord_t'(HA_START);
    bar     = 3'(col / coord_t'(BAR_W));
    pix_rgb = vif.test_mode ? bar_color(bar) : rgb_t'(vif.rgb_color);
  end
`else
  assign pix_rgb = rgb_t'(vif.rgb_color);
`endif

  // Output register: final delay stage plus colour, polarity applied here.
  always_comb begin
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (vif.pix_en) begin
      hsync_d   = dly.hs ^ ~SYNC_POL;
      vsync_d   = dly.vs ^ ~SYNC_POL;
      blank_n_d = dly.act;
      rgb_d     = dly.act ? pix_rgb : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frame_start = frame_start_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.blank_n     = blank_n_q;
  assign vif.vga_r       = rgb_q.r;
  assign vif.vga_g       = rgb_q.g;
  assign vif.vga_b       = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Testbench: tb_vga_timing_controller
// Table-driven checks of the default 640x480 controller (PIX_LAT=2, active-low
// sync) plus hand sequences for line timing, async mid-line reset, pix_en
// stalls, and a small-timing instance that reaches the x/y corner wrap quickly.
module tb_vga_timing_controller;
  import vga_pkg::*;

  localparam int LAT = 2;  // PIX_LAT of the main instance

  logic clk = 1'b0;
  logic reset;
  logic reset_s;
  always #5 clk = ~clk;

  vga_timing_controller_if vif ();
  vga_timing_controller_if sif ();

  vga_timing_controller dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  // 12 x 5 frame (60 cycles): H 2+1+8+1, V 1+1+2+1.
  vga_timing_controller #(
    .H_SYNC (2), .H_BP (1), .H_ACTIVE (8), .H_FP (1),
    .V_SYNC (1), .V_BP (1), .V_ACTIVE (2), .V_FP (1)
  ) dut_s (
    .clk   (clk),
    .reset (reset_s),
    .vif   (sif)
  );

  typedef struct {
    int          n;      // enabled cycles since reset release
    int          x;
    int          y;
    bit          fs;
    bit          hs;
    bit          vs;
    bit          bl;
    logic [23:0] rgb;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_pins(input string tag, input vec_t e);
    check({tag, ".x"},           32'(vif.x), 32'(e.x));
    check({tag, ".y"},           32'(vif.y), 32'(e.y));
    check({tag, ".frame_start"}, 32'(vif.frame_start), 32'(e.fs));
    check({tag, ".hsync"},       32'(vif.hsync), 32'(e.hs));
    check({tag, ".vsync"},       32'(vif.vsync), 32'(e.vs));
    check({tag, ".blank_n"},     32'(vif.blank_n), 32'(e.bl));
    check({tag, ".rgb"},         32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(e.rgb));
  endtask

  // Renderer model: colour for the coordinate presented LAT enabled cycles ago.
  function automatic logic [23:0] model_rgb(input int k);
    int c;
    c = k - LAT;
    if (c < 0) return 24'h0;
    return {8'(c % 800), 8'((c / 800) % 525), 8'h5A};
  endfunction

  // Expected pins after k enabled cycles since reset release (pins lag x/y by LAT+1).
  function automatic vec_t model_at(input int k);
    vec_t e;
    int c, cx, cy;
    e.n  = k;
    e.x  = k % 800;
    e.y  = (k / 800) % 525;
    e.fs = (k >= 1) && (((k - 1) % 420000) == 0);
    c    = k - (LAT + 1);
    if (c < 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.rgb = 24'h0;
    end else begin
      cx   = c % 800;
      cy   = (c / 800) % 525;
      e.hs = !(cx < 96);
      e.vs = !(cy < 2);
      e.bl = (cx >= 144) && (cx < 784) && (cy >= 35) && (cy < 515);
      e.rgb = e.bl ? {8'(cx), 8'(cy), 8'h5A} : 24'h0;
    end
    return e;
  endfunction

  // One clock: drive at negedge, let the posedge happen, sample at next negedge.
  task automatic tick(input bit en);
    vif.pix_en    = en;
    vif.rgb_color = model_rgb(n);
    @(posedge clk);
    if (en) n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    vif.pix_en    = 1'b1;
    vif.rgb_color = 24'h0;
    repeat (5) @(negedge clk);
    check("rst.x",       32'(vif.x), 32'd0);
    check("rst.y",       32'(vif.y), 32'd0);
    check("rst.hsync",   32'(vif.hsync), 32'd1);
    check("rst.vsync",   32'(vif.vsync), 32'd1);
    check("rst.blank_n", 32'(vif.blank_n), 32'd0);
    check("rst.rgb",     32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'd0);
    reset = 1'b1;
    n     = 0;
  endtask

  vec_t vecs[$];

  initial begin
    reset         = 1'b0;
    reset_s       = 1'b0;
    vif.pix_en    = 1'b0;
    vif.rgb_color = 24'h0;
    sif.pix_en    = 1'b0;
    sif.rgb_color = 24'h0;
`ifdef TEST_PATTERN_EN
    vif.test_mode = 1'b0;
    sif.test_mode = 1'b0;
`endif

    //            n      x    y  fs hs vs bl rgb
    vecs.push_back('{0,     0,   0,  0, 1, 1, 0, 24'h000000});
    vecs.push_back('{1,     1,   0,  1, 1, 1, 0, 24'h000000});
    vecs.push_back('{2,     2,   0,  0, 1, 1, 0, 24'h000000});
    vecs.push_back('{3,     3,   0,  0, 0, 0, 0, 24'h000000});
    vecs.push_back('{98,    98,  0,  0, 0, 0, 0, 24'h000000});
    vecs.push_back('{99,    99,  0,  0, 1, 0, 0, 24'h000000});
    vecs.push_back('{803,   3,   1,  0, 0, 0, 0, 24'h000000});
    vecs.push_back('{1602,  2,   2,  0, 1, 0, 0, 24'h000000});
    vecs.push_back('{1603,  3,   2,  0, 0, 1, 0, 24'h000000});
    vecs.push_back('{27403, 203, 34, 0, 1, 1, 0, 24'h000000});
    vecs.push_back('{28146, 146, 35, 0, 1, 1, 0, 24'h000000});
    vecs.push_back('{28147, 147, 35, 0, 1, 1, 1, 24'h90235A});
    vecs.push_back('{28786, 786, 35, 0, 1, 1, 1, 24'h0F235A});
    vecs.push_back('{28787, 787, 35, 0, 1, 1, 0, 24'h000000});

    // ---- reset and table-driven vectors ----
    do_reset();
    foreach (vecs[i]) begin
      while (n < vecs[i].n) tick(1'b1);
      check_pins($sformatf("vec%0d", vecs[i].n), vecs[i]);
    end

    // ---- line timing: hsync low width and falling-edge period ----
    begin
      int  t_fall1, t_fall2, t_rise;
      bit  prev;
      t_fall1 = -1; t_fall2 = -1; t_rise = -1;
      prev    = vif.hsync;
      for (int i = 0; i < 2000 && t_fall2 < 0; i++) begin
        tick(1'b1);
        if (prev && !vif.hsync) begin
          if (t_fall1 < 0) t_fall1 = i;
          else             t_fall2 = i;
        end
        if (!prev && vif.hsync && t_fall1 >= 0 && t_rise < 0) t_rise = i;
        prev = vif.hsync;
      end
      check("hsync_low_width", 32'(t_rise - t_fall1), 32'd96);
      check("hsync_period",    32'(t_fall2 - t_fall1), 32'd800);
    end

    // ---- async reset mid-line ----
    #2 reset = 1'b0;
    #1;
    check("async_rst.x",       32'(vif.x), 32'd0);
    check("async_rst.y",       32'(vif.y), 32'd0);
    check("async_rst.hsync",   32'(vif.hsync), 32'd1);
    check("async_rst.vsync",   32'(vif.vsync), 32'd1);
    check("async_rst.blank_n", 32'(vif.blank_n), 32'd0);
    check("async_rst.fs",      32'(vif.frame_start), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n     = 0;
    tick(1'b1);
    check("post_rst.x",  32'(vif.x), 32'd1);
    check("post_rst.fs", 32'(vif.frame_start), 32'd1);

    // ---- stall: pix_en alternating 0,1; outputs must follow the model and hold ----
    begin
      int low_clks;
      low_clks = 0;
      for (int i = 0; i < 500; i++) begin
        tick(i[0]);
        check_pins("stall", model_at(n));
        if (!vif.hsync) low_clks++;
      end
      check("stall_hsync_width", 32'(low_clks), 32'd192);
      check("stall_x_final", 32'(vif.x), 32'd251);
    end
    vif.pix_en = 1'b0;

    // ---- small-timing instance: corner wrap and frame_start period ----
    begin
      int fs_cnt, fs_first, fs_second;
      fs_cnt = 0; fs_first = -1; fs_second = -1;
      @(negedge clk);
      reset_s    = 1'b1;
      sif.pix_en = 1'b1;
      for (int k = 1; k <= 120; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k == 59) begin
          check("corner.x_before", 32'(sif.x), 32'd11);
          check("corner.y_before", 32'(sif.y), 32'd4);
        end
        if (k == 60) begin
          check("corner.x_wrap", 32'(sif.x), 32'd0);
          check("corner.y_wrap", 32'(sif.y), 32'd0);
        end
        if (sif.frame_start) begin
          fs_cnt++;
          if (fs_first < 0)       fs_first  = k;
          else if (fs_second < 0) fs_second = k;
        end
      end
      check("small.fs_count",  32'(fs_cnt), 32'd2);
      check("small.fs_first",  32'(fs_first), 32'd1);
      check("small.fs_period", 32'(fs_second - fs_first), 32'd60);
      sif.pix_en = 1'b0;
    end

`ifdef TEST_PATTERN_EN
    // ---- test pattern: bars replace renderer colour, blanking unchanged ----
    do_reset();
    vif.test_mode = 1'b1;
    while (n < 28146) tick(1'b1);
    check("tp.blank_before", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'h000000);
    tick(1'b1);
    check("tp.col0",   32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'hFFFFFF);
    while (n < 28227) tick(1'b1);
    check("tp.col80",  32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'hFFFF00);
    while (n < 28786) tick(1'b1);
    check("tp.col639", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'h000000);
    check("tp.col639_blank_n", 32'(vif.blank_n), 32'd1);
    tick(1'b1);
    check("tp.blank_after", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'h000000);
    check("tp.blank_after_blank_n", 32'(vif.blank_n), 32'd0);
    vif.test_mode = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
